seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive cycles an {anode,led} pattern must hold before capture; legal range 2..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: cycles without a refresh before a digit is invalidated; used only with SEG_SCAN_TIMEOUT_EN.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 led  input  7  segment lines, active-low; led[0]=a .. led[6]=g.
REQ-006 anode  input  4  digit-select lines, active-low; anode[0]=digit 0 (rightmost).
REQ-007 digits  output  16  captured hex values; digit n in bits [4n+3:4n].
REQ-008 digit_valid  output  4  per-digit flag: digits[n] holds a currently valid decode.
REQ-009 frame_done  output  1  one-cycle pulse when all four digits have been captured since the last pulse.
REQ-010 code_err  output  1  one-cycle pulse on capture of a non-hex, non-blank segment pattern.
REQ-011 multi_err  output  1  one-cycle pulse on capture of a pattern with more than one anode low.

Function
REQ-012 Inputs SHALL be registered once; all comparisons use the registered sample.
REQ-013 Stability counter SHALL clear when the registered sample differs from the previous one, else increment, saturating at STABLE_CYCLES.
REQ-014 FSM states IDLE, SETTLE, LOCKED: IDLE->SETTLE on any change; SETTLE->LOCKED on counter reaching STABLE_CYCLES-1, which is the capture cycle; LOCKED/SETTLE->SETTLE on any change; anode=4'b1111 -> IDLE.
REQ-015 Latency: a pattern first present at input edge k SHALL be reflected in outputs after edge k+STABLE_CYCLES+1; exactly one capture per stable pattern.
REQ-016 Capture, one-hot anode, hex pattern (standard 0-F glyphs, b/d lowercase): digits[n] updated, digit_valid[n] set, seen[n] set.
REQ-017 Capture, one-hot anode, all segments off (7'h7F): digit_valid[n] cleared, digits[n] unchanged, no error.
REQ-018 Capture, one-hot anode, unknown glyph: code_err pulse, digit_valid[n] cleared, digits[n] unchanged, seen[n] not set.
REQ-019 Capture with two or more anodes low: multi_err pulse, no digit state change.
REQ-020 Anode all high: no capture, counter held cleared.
REQ-021 When seen becomes 4'b1111, frame_done SHALL pulse on the same edge as the completing capture and seen SHALL clear; repeat captures of an already-seen digit do not pulse.
REQ-022 code_err, multi_err, frame_done SHALL never be asserted in two consecutive cycles for the same stable pattern.

Reset
REQ-023 rst_n low at a rising edge: digits=16'h0000, digit_valid=4'b0000, frame_done=code_err=multi_err=0, seen=0, counter=0, FSM=IDLE, input register = {4'hF,7'h7F}.
REQ-024 Reset mid-SETTLE SHALL abandon the pending capture; after release, the pattern must again hold STABLE_CYCLES.

Configuration
REQ-025 Macro SEG_SCAN_TIMEOUT_EN defined: per-digit counters clear on every capture of that digit and, on reaching TIMEOUT_CYCLES, clear digit_valid[n] and seen[n] (digits[n] retained).
REQ-026 Macro undefined: no timeout counters are instantiated; digit_valid changes only per REQ-016..018 and reset.

Structure
REQ-027 Package seg_scan_pkg SHALL hold the FSM state enum, the sixteen glyph constants, and the blank constant 7'h7F.
REQ-028 Combinational sub-module seg7_to_hex SHALL map led[6:0] to {hit, blank, value[3:0]}; the top instantiates it once.

Verification
REQ-029 Reset: hold rst_n=0 three cycles with anode=4'b1110, led=glyph 5 -> all outputs zero; after release, capture occurs only after 4 stable cycles.
REQ-030 Scan 0x1A3F (anode 1110,1101,1011,0111, 8 cycles each) -> digits=16'h1A3F, digit_valid=4'hF, single frame_done on the fourth capture.
REQ-031 Glitch: pattern held 3 cycles then changed -> no capture, outputs unchanged.
REQ-032 anode=4'b1100 stable 6 cycles -> one multi_err pulse, digits unchanged; led=7'b0000000 (all on, glyph 8) valid, led=7'b1111110 (only a) -> code_err pulse and digit_valid[n]=0.
REQ-033 Blank: anode=4'b1011, led=7'h7F stable -> digit_valid[2]=0, no error pulse.
REQ-034 With SEG_SCAN_TIMEOUT_EN, TIMEOUT_CYCLES=50: capture digit 0 then anode=4'hF for 50 cycles -> digit_valid[0] clears; without the macro it stays set.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the seven-segment scan decoder.
//   state_e   - capture FSM states
//   scan_t    - one registered {anode, led} sample
//   seg_dec_t - glyph decode result {hit, blank, value}
//   GLYPH_0..GLYPH_F, SEG_BLANK - active-low segment patterns, led[0]=a .. led[6]=g
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] led;
  } scan_t;

  typedef struct packed {
    logic       hit;
    logic       blank;
    logic [3:0] value;
  } seg_dec_t;

  // Active-low glyphs (0 = segment lit); b and d are the lowercase shapes.
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [15:0][6:0] GLYPH_TAB = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  // Input register reset value: no digit selected, all segments dark.
  localparam scan_t SCAN_RST = '{anode: 4'hF, led: SEG_BLANK};

endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: combinational seven-segment glyph decoder.
//   led_i [6:0] - active-low segments, led_i[0]=a .. led_i[6]=g
//   dec_o       - {hit: matches a 0-F glyph, blank: all dark, value: hex digit}
module seg7_to_hex
  import seg_scan_pkg::*;
(
  input  logic [6:0] led_i,
  output seg_dec_t   dec_o
);

  always_comb begin
    dec_o       = '0;
    dec_o.blank = (led_i == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (led_i == GLYPH_TAB[i]) begin
        dec_o.hit   = 1'b1;
        dec_o.value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers four hex digits from a multiplexed seven-segment
// display scan (active-low anodes and segments).
//   clk, rst_n      - clock, synchronous active-low reset
//   led [6:0]       - segment lines, active-low, led[0]=a .. led[6]=g
//   anode [3:0]     - digit selects, active-low, anode[0]=rightmost digit
//   digits [15:0]   - captured values, digit n in [4n+3:4n]
//   digit_valid [3:0] - digit n holds a currently valid decode
//   frame_done      - pulse when all four digits captured since last pulse
//   code_err        - pulse on capture of an unknown glyph
//   multi_err       - pulse on capture with more than one anode low
// Optional build macro SEG_SCAN_TIMEOUT_EN adds per-digit staleness counters
// that drop digit_valid after TIMEOUT_CYCLES cycles without a refresh.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  led,
  input  logic [3:0]  anode,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        code_err,
  output logic        multi_err
);

  scan_t           samp_q, prev_q;
  state_e          state_q;
  logic [7:0]      cnt_q;
  logic [3:0][3:0] digits_q, digits_d;
  logic [3:0]      valid_q, valid_d;
  logic [3:0]      seen_q, seen_d;
  logic            fd_q, fd_d, ce_q, ce_d, me_q, me_d;

  logic [3:0]      an_n, cap_mask, tmo_hit;
  logic [1:0]      idx;
  logic            chg, idle_pat, one_hot, capture;
  seg_dec_t        dec;

  seg7_to_hex u_dec (
    .led_i (samp_q.led),
    .dec_o (dec)
  );

  assign an_n     = ~samp_q.anode;
  assign chg      = (samp_q != prev_q);
  assign idle_pat = (an_n == 4'd0);
  assign one_hot  = !idle_pat && ((an_n & (an_n - 4'd1)) == 4'd0);
  // Capture fires on the one cycle the counter sits at STABLE_CYCLES-1 while
  // still settling; afterwards the FSM is LOCKED so a held pattern never repeats.
  assign capture  = (state_q == ST_SETTLE) && !chg && !idle_pat &&
                    (cnt_q == 8'(STABLE_CYCLES - 1));
  assign cap_mask = (capture && one_hot) ? an_n : 4'd0;

  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (an_n[i]) idx = 2'(i);
  end

`ifdef SEG_SCAN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  for (genvar n = 0; n < 4; n++) begin : g_tmo
    logic [TMO_W-1:0] tmo_q;
    always_ff @(posedge clk) begin
      if (!rst_n)                                   tmo_q <= '0;
      else if (cap_mask[n])                         tmo_q <= '0;
      else if (tmo_q != TMO_W'(TIMEOUT_CYCLES))     tmo_q <= tmo_q + TMO_W'(1);
    end
    // A capture of this digit in the same cycle refreshes it instead.
    assign tmo_hit[n] = !cap_mask[n] && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  end
`else
  logic unused_tmo;
  assign unused_tmo = |32'(TIMEOUT_CYCLES);
  assign tmo_hit    = 4'd0;
`endif

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q & ~tmo_hit;
    seen_d   = seen_q & ~tmo_hit;
    fd_d     = 1'b0;
    ce_d     = 1'b0;
    me_d     = 1'b0;
    if (capture) begin
      if (!one_hot) begin
        me_d = 1'b1;
      end else if (dec.hit) begin
        digits_d[idx] = dec.value;
        valid_d       = valid_d | cap_mask;
        seen_d        = seen_d | cap_mask;
        if (seen_d == 4'hF) begin
          fd_d   = 1'b1;
          seen_d = 4'd0;
        end
      end else begin
        // Blank and unknown glyphs both invalidate; only unknown is an error.
        valid_d = valid_d & ~cap_mask;
        ce_d    = !dec.blank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_q   <= SCAN_RST;
      prev_q   <= SCAN_RST;
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      digits_q <= '0;
      valid_q  <= 4'd0;
      seen_q   <= 4'd0;
      fd_q     <= 1'b0;
      ce_q     <= 1'b0;
      me_q     <= 1'b0;
    end else begin
      samp_q   <= {anode, led};
      prev_q   <= samp_q;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      fd_q     <= fd_d;
      ce_q     <= ce_d;
      me_q     <= me_d;
      if (idle_pat) begin
        state_q <= ST_IDLE;
        cnt_q   <= 8'd0;
      end else if (chg) begin
        state_q <= ST_SETTLE;
        cnt_q   <= 8'd0;
      end else begin
        if (cnt_q < 8'(STABLE_CYCLES)) cnt_q <= cnt_q + 8'd1;
        if (capture)                   state_q <= ST_LOCKED;
      end
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = fd_q;
  assign code_err    = ce_q;
  assign multi_err   = me_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus a
// randomized scan compared cycle by cycle against a behavioural model.
module tb_seg_scan_decoder;

  localparam int S = 4;
  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  led = 7'h7F;
  logic [3:0]  anode = 4'hF;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done, code_err, multi_err;

  int checks = 0;
  int fails  = 0;

  seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .led         (led),
    .anode       (anode),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .code_err    (code_err),
    .multi_err   (multi_err)
  );

  always #5 clk = ~clk;

  // Lit segments per hex digit, active-high, bit0=a .. bit6=g.
  logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] glyph(input int v);
    return ~seg_on[v];
  endfunction

  // 0..15 hex value, 16 blank, -1 unknown
  function automatic int model_decode(input logic [6:0] l);
    if (l == 7'h7F) return 16;
    for (int i = 0; i < 16; i++)
      if (l == ~seg_on[i]) return i;
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  // A pattern is captured once its input has been sampled on S+1 consecutive
  // edges; its effects appear on the following edge.
  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_seen;
  logic        m_fd, m_ce, m_me;
  logic [10:0] m_last;
  int          m_run;
  int          m_age [4];

  always @(posedge clk) begin
    int cap_n, zeros, val;
    m_fd = 1'b0; m_ce = 1'b0; m_me = 1'b0;
    if (!rst_n) begin
      m_digits = '0; m_valid = '0; m_seen = '0;
      m_last = {4'hF, 7'h7F}; m_run = 1;
      for (int n = 0; n < 4; n++) m_age[n] = 0;
    end else begin
      cap_n = -1; zeros = 0;
      if (m_run == S + 1 && m_last[10:7] != 4'hF) begin
        for (int n = 0; n < 4; n++)
          if (!m_last[7+n]) begin zeros++; cap_n = n; end
        if (zeros > 1) begin m_me = 1'b1; cap_n = -1; end
      end
`ifdef SEG_SCAN_TIMEOUT_EN
      for (int n = 0; n < 4; n++)
        if (n != cap_n && m_age[n] < T) begin
          m_age[n]++;
          if (m_age[n] == T) begin m_valid[n] = 1'b0; m_seen[n] = 1'b0; end
        end
`endif
      if (cap_n >= 0) begin
        m_age[cap_n] = 0;
        val = model_decode(m_last[6:0]);
        if (val == 16) m_valid[cap_n] = 1'b0;
        else if (val < 0) begin m_valid[cap_n] = 1'b0; m_ce = 1'b1; end
        else begin
          m_digits[4*cap_n +: 4] = val[3:0];
          m_valid[cap_n] = 1'b1;
          m_seen[cap_n]  = 1'b1;
          if (m_seen == 4'hF) begin m_fd = 1'b1; m_seen = 4'h0; end
        end
      end
      if ({anode, led} == m_last) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_last = {anode, led};
        m_run  = 1;
      end
    end
  end

  // Drive one cycle: apply inputs, let one edge pass, sample 1 time unit later.
  task automatic cyc(input logic [3:0] a, input logic [6:0] l);
    anode = a; led = l;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(4'hF, 7'h7F);
    cyc(4'hF, 7'h7F);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1110, glyph(5));
      checks++;
      if ({digits, digit_valid, frame_done, code_err, multi_err} !== 23'd0) begin
        fails++; $display("FAIL reset_outputs got=%h required=0", {digits, digit_valid, frame_done, code_err, multi_err});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1110, glyph(5));
      checks++;
      if (digit_valid !== 4'b0000) begin
        fails++; $display("FAIL reset_early_capture cyc=%0d got=%b required=0000", i, digit_valid);
      end
    end
    cyc(4'b1110, glyph(5));
    checks++;
    if (digit_valid !== 4'b0001 || digits !== 16'h0005) begin
      fails++; $display("FAIL reset_first_capture got=%h/%b required=0005/0001", digits, digit_valid);
    end
    // Reset during settling drops the pending capture; the count restarts.
    for (int i = 0; i < 3; i++) cyc(4'b1101, glyph(9));
    rst_n = 1'b0;
    cyc(4'b1101, glyph(9));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(4'b1101, glyph(9));
    checks++;
    if (digit_valid !== 4'b0000) begin
      fails++; $display("FAIL reset_mid_settle got=%b required=0000", digit_valid);
    end
    cyc(4'b1101, glyph(9));
    checks++;
    if (digit_valid !== 4'b0010 || digits !== 16'h0090) begin
      fails++; $display("FAIL reset_mid_settle_capture got=%h/%b required=0090/0010", digits, digit_valid);
    end
  endtask

  task automatic test_scan();
    logic [3:0] an [4];
    int         val [4];
    int         fd_cnt, fd_at, k;
    an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    val = '{15, 3, 10, 1};
    fd_cnt = 0; fd_at = -1; k = 0;
    do_reset();
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 8; c++) begin
        cyc(an[d], glyph(val[d]));
        if (frame_done) begin fd_cnt++; fd_at = k; end
        checks++;
        if ({digits, digit_valid, frame_done, code_err, multi_err} !== {m_digits, m_valid, m_fd, m_ce, m_me}) begin
          fails++; $display("FAIL scan_model k=%0d got=%h required=%h", k,
            {digits, digit_valid, frame_done, code_err, multi_err}, {m_digits, m_valid, m_fd, m_ce, m_me});
        end
        k++;
      end
    checks++;
    if (digits !== 16'h1A3F || digit_valid !== 4'hF) begin
      fails++; $display("FAIL scan_result got=%h/%h required=1a3f/f", digits, digit_valid);
    end
    checks++;
    if (fd_cnt !== 1 || fd_at !== 29) begin
      fails++; $display("FAIL scan_frame_done count=%0d at=%0d required=1 at 29", fd_cnt, fd_at);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 9; i++) begin
      if (i < 3) cyc(4'b1110, glyph(7));
      else       cyc(4'hF, 7'h7F);
      checks++;
      if (digits !== 16'h1A3F || digit_valid !== 4'hF || {frame_done, code_err, multi_err} !== 3'b000) begin
        fails++; $display("FAIL glitch_no_capture i=%0d got=%h/%h/%b", i, digits, digit_valid, {frame_done, code_err, multi_err});
      end
    end
  endtask

  task automatic test_errors();
    int me_cnt, ce_cnt;
    me_cnt = 0; ce_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) cyc(4'b1100, glyph(2));
      else       cyc(4'hF, 7'h7F);
      me_cnt += int'(multi_err);
    end
    checks++;
    if (me_cnt !== 1 || digits !== 16'h1A3F || digit_valid !== 4'hF) begin
      fails++; $display("FAIL multi_err pulses=%0d digits=%h valid=%h required=1/1a3f/f", me_cnt, digits, digit_valid);
    end
    for (int i = 0; i < 8; i++) cyc(4'b1110, 7'b0000000);
    checks++;
    if (digits[3:0] !== 4'h8 || digit_valid[0] !== 1'b1) begin
      fails++; $display("FAIL glyph8 got=%h/%b required=8/1", digits[3:0], digit_valid[0]);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1110, 7'b1111110);
      ce_cnt += int'(code_err);
    end
    checks++;
    if (ce_cnt !== 1 || digit_valid[0] !== 1'b0 || digits[3:0] !== 4'h8) begin
      fails++; $display("FAIL code_err pulses=%0d valid0=%b d0=%h required=1/0/8", ce_cnt, digit_valid[0], digits[3:0]);
    end
  endtask

  task automatic test_blank();
    int err_cnt;
    err_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1011, 7'h7F);
      err_cnt += int'(code_err) + int'(multi_err);
    end
    checks++;
    if (digit_valid[2] !== 1'b0 || err_cnt !== 0 || digits[11:8] !== 4'hA) begin
      fails++; $display("FAIL blank valid2=%b errs=%0d d2=%h required=0/0/a", digit_valid[2], err_cnt, digits[11:8]);
    end
  endtask

  task automatic test_timeout();
    logic exp_v0;
`ifdef SEG_SCAN_TIMEOUT_EN
    exp_v0 = 1'b0;
`else
    exp_v0 = 1'b1;
`endif
    for (int i = 0; i < 8; i++) cyc(4'b1110, glyph(4));
    checks++;
    if (digit_valid[0] !== 1'b1 || digits[3:0] !== 4'h4) begin
      fails++; $display("FAIL timeout_capture got=%b/%h required=1/4", digit_valid[0], digits[3:0]);
    end
    for (int i = 0; i < 60; i++) cyc(4'hF, 7'h7F);
    checks++;
    if (digit_valid[0] !== exp_v0 || digits[3:0] !== 4'h4) begin
      fails++; $display("FAIL timeout_valid got=%b/%h required=%b/4", digit_valid[0], digits[3:0], exp_v0);
    end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [6:0] l;
    int r, hold;
    do_reset();
    for (int seg = 0; seg < 260; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      a = 4'hF;
      else if (r < 7) a = ~(4'b0001 << $urandom_range(0, 3));
      else            a = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 12);
      if (r < 10)      l = glyph($urandom_range(0, 15));
      else if (r == 10) l = 7'h7F;
      else             l = 7'($urandom_range(0, 127));
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 39) == 0) rst_n = 1'b0;
      for (int c = 0; c < hold; c++) begin
        cyc(a, l);
        rst_n = 1'b1;
        checks++;
        if ({digits, digit_valid, frame_done, code_err, multi_err} !== {m_digits, m_valid, m_fd, m_ce, m_me}) begin
          fails++; $display("FAIL random_model seg=%0d got=%h required=%h", seg,
            {digits, digit_valid, frame_done, code_err, multi_err}, {m_digits, m_valid, m_fd, m_ce, m_me});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_errors();
    test_blank();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
